fp_add_pipe: RTL

- Parametrised, 3-stage pipelined IEEE-754 binary floating-point adder/subtractor with valid/ready handshakes on input and output.
- Sits in the FP datapath as the streaming replacement for the single-cycle combinational adder.
- Adds a subtract mode, a configurable format, Inf/NaN handling, overflow to infinity, and backpressure.

---
 rtl/fp_add_pipe.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_pipe
// Three-stage pipelined IEEE-754 binary floating-point adder/subtractor with
// valid/ready handshakes on both sides. Round-to-nearest-even, subnormal
// support, Inf/NaN handling and overflow to infinity. All stages advance
// together, so a stalled output freezes the whole pipe.
//
// Parameters:
//   EXP_W      exponent field width (bias = 2^(EXP_W-1)-1)
//   MAN_W      stored fraction width (hidden bit excluded)
//
// Ports (word width W = 1+EXP_W+MAN_W):
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, discards in-flight data
//   in_valid   operand pair valid
//   in_ready   pipe can accept operands this cycle (combinational)
//   in_a/in_b  operands A and B
//   in_sub     1: A - B, 0: A + B
//   out_valid  registered result valid
//   out_ready  downstream accepts result
//   out_s      registered rounded result
//   out_flags  {invalid, overflow, underflow, inexact}, only when the
//              macro FP_ADD_PIPE_FLAGS_EN is defined
// ---------------------------------------------------------------------------
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_s
`ifdef FP_ADD_PIPE_FLAGS_EN
    ,
    output logic [3:0]           out_flags
`endif
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int F    = MAN_W + 3;           // hidden, fraction, guard, round
    localparam int N    = MAN_W + 4;           // F plus sticky in the LSB
    localparam int EW2  = EXP_W + 2;           // headroom for carry + round
    localparam int SH_W = $clog2(F + 1);
    localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EW2-1:0] E_MAX = {2'b00, {EXP_W{1'b1}}};

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: unpack, order by magnitude, align the smaller operand
    // ------------------------------------------------------------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, ex, ey, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb, mx, my;
    logic             a_nan, b_nan, a_inf, b_inf, a_ge_b, sx, sy;
    logic [SH_W-1:0]  sh1;
    logic [2*F-1:0]   wide;
    logic             st1_special;
    logic [W-1:0]     st1_spec_val;

    assign sa = in_a[W-1];
    assign ea = in_a[W-2:MAN_W];
    assign fa = in_a[MAN_W-1:0];
    assign sb = in_b[W-1] ^ in_sub;
    assign eb = in_b[W-2:MAN_W];
    assign fb = in_b[MAN_W-1:0];

    always_comb begin
        a_nan  = (ea == {EXP_W{1'b1}}) && (fa != '0);
        b_nan  = (eb == {EXP_W{1'b1}}) && (fb != '0);
        a_inf  = (ea == {EXP_W{1'b1}}) && (fa == '0);
        b_inf  = (eb == {EXP_W{1'b1}}) && (fb == '0);
        ea_eff = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff = (eb == '0) ? EXP_W'(1) : eb;
        ma     = {ea != '0, fa};
        mb     = {eb != '0, fb};
        // Raw {exp, frac} ordering equals magnitude ordering in IEEE encoding
        a_ge_b = {ea, fa} >= {eb, fb};
        if (a_ge_b) begin
            sx = sa; sy = sb; ex = ea_eff; ey = eb_eff; mx = ma; my = mb;
        end else begin
            sx = sb; sy = sa; ex = eb_eff; ey = ea_eff; mx = mb; my = ma;
        end
        diff = ex - ey;
        // Shifts of F or more collapse the operand entirely into sticky
        if (int'(diff) >= F) sh1 = SH_W'(F);
        else                 sh1 = SH_W'(diff);
        wide = {my, 2'b00, {F{1'b0}}} >> sh1;

        st1_special  = 1'b0;
        st1_spec_val = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            st1_special  = 1'b1;
            st1_spec_val = QNAN;
        end else if (a_inf) begin
            st1_special  = 1'b1;
            st1_spec_val = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            st1_special  = 1'b1;
            st1_spec_val = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic             v1, s1_sign, s1_eff_sub, s1_special, s1_zsign;
    logic [EXP_W-1:0] s1_exp;
    logic [N-1:0]     s1_mx, s1_my;
    logic [W-1:0]     s1_spec_val;

    // Stage 1 register; zero-result sign is negative only if both effective
    // signs are negative, which also makes x - x come out as +0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            s1_sign     <= 1'b0;
            s1_eff_sub  <= 1'b0;
            s1_special  <= 1'b0;
            s1_zsign    <= 1'b0;
            s1_exp      <= '0;
            s1_mx       <= '0;
            s1_my       <= '0;
            s1_spec_val <= '0;
        end else if (adv) begin
            v1          <= in_valid;
            s1_sign     <= sx;
            s1_eff_sub  <= sx ^ sy;
            s1_special  <= st1_special;
            s1_zsign    <= sa & sb;
            s1_exp      <= ex;
            s1_mx       <= {mx, 3'b000};
            s1_my       <= {wide[2*F-1:F], |wide[F-1:0]};
            s1_spec_val <= st1_spec_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude add/subtract. Sticky sits in the LSB so that a
    // subtraction borrows through it and rounding stays correct.
    // ------------------------------------------------------------------
    logic [N:0] sum_d;
    always_comb begin
        if (s1_eff_sub) sum_d = {1'b0, s1_mx} - {1'b0, s1_my};
        else            sum_d = {1'b0, s1_mx} + {1'b0, s1_my};
    end

    logic             v2, s2_sign, s2_special, s2_zsign;
    logic [EXP_W-1:0] s2_exp;
    logic [N:0]       s2_sum;
    logic [W-1:0]     s2_spec_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2          <= 1'b0;
            s2_sign     <= 1'b0;
            s2_special  <= 1'b0;
            s2_zsign    <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_spec_val <= '0;
        end else if (adv) begin
            v2          <= v1;
            s2_sign     <= s1_sign;
            s2_special  <= s1_special;
            s2_zsign    <= s1_zsign;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_d;
            s2_spec_val <= s1_spec_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize, round to nearest even, pack
    // ------------------------------------------------------------------
    logic [N-1:0]     m;
    logic [EW2-1:0]   e, e_enc;
    int               lz, sh3;
    logic             g, r, st, lsb, rnd_up, ovf;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     res;

    always_comb begin
        m     = '0;
        e     = {2'b00, s2_exp};
        e_enc = '0;
        lz    = N;
        sh3   = 0;
        frac  = '0;
        res   = '0;
        if (s2_sum[N]) begin
            m    = s2_sum[N:1];
            m[0] = s2_sum[1] | s2_sum[0];
            e    = e + EW2'(1);
        end else begin
            m = s2_sum[N-1:0];
            for (int i = 0; i < N; i++) begin
                if (m[i]) lz = N - 1 - i;
            end
            // Never normalize below exponent 1; what remains is subnormal
            sh3 = (lz > int'(e) - 1) ? int'(e) - 1 : lz;
            m   = m << sh3;
            e   = e - EW2'(sh3);
        end
        lsb    = m[3];
        g      = m[2];
        r      = m[1];
        st     = m[0];
        rnd_up = g & (r | st | lsb);
        mant   = {1'b0, m[N-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant[MAN_W+1]) begin
            e_enc = e + EW2'(1);
            frac  = mant[MAN_W:1];
        end else begin
            e_enc = mant[MAN_W] ? e : '0;
            frac  = mant[MAN_W-1:0];
        end
        ovf = (e_enc >= E_MAX);
        if (s2_special)
            res = s2_spec_val;
        else if (s2_sum == '0)
            res = {s2_zsign, {(W-1){1'b0}}};
        else if (ovf)
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            res = {s2_sign, e_enc[EXP_W-1:0], frac};
    end

`ifdef FP_ADD_PIPE_FLAGS_EN
    logic       s1_invalid, s2_invalid, inexact;
    logic [3:0] flags_d;

    // Invalid covers Inf-Inf and signalling-NaN inputs (fraction MSB clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_invalid <= 1'b0;
            s2_invalid <= 1'b0;
        end else if (adv) begin
            s1_invalid <= (a_inf && b_inf && (sa != sb)) ||
                          (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
            s2_invalid <= s1_invalid;
        end
    end

    always_comb begin
        flags_d = 4'b0000;
        inexact = g | r | st | ovf;
        if (s2_special)
            flags_d = {s2_invalid, 3'b000};
        else if (s2_sum != '0)
            flags_d = {1'b0, ovf, !ovf && (e_enc == '0) && inexact, inexact};
    end
`endif

    // Output register holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
`ifdef FP_ADD_PIPE_FLAGS_EN
            out_flags <= 4'b0000;
`endif
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                out_s     <= res;
`ifdef FP_ADD_PIPE_FLAGS_EN
                out_flags <= flags_d;
`endif
            end
        end
    end

endmodule
